// File: rtl/sprite_line_engine.sv
// sprite_line_engine: per-scanline sprite evaluation in hblank, pattern row fetch, and registered pixel output
module sprite_line_engine #(
  parameter int NUM_SPRITES  = 16,
  parameter int MAX_PER_LINE = 8,
  parameter int SPRITE_W     = 16,
  parameter int SPRITE_H     = 16,
  parameter int BPP          = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           attr_we,
  input  logic [$clog2(NUM_SPRITES)-1:0] attr_addr,
  input  logic [31:0]                    attr_wdata,
  input  logic [10:0]                    hcount,
  input  logic [9:0]                     vcount,
  output logic [7:0]                     pat_addr,
  input  logic [SPRITE_W*BPP-1:0]        pat_rdata,
  output logic                           pix_valid,
  output logic [2+BPP:0]                 pix_color,
  output logic                           overflow,
  output logic                           busy
);
  localparam int IW = $clog2(NUM_SPRITES);
  localparam int SW = $clog2(MAX_PER_LINE);
  localparam int NW = SW + 1;
  localparam int OW = $clog2(SPRITE_W);
  typedef enum logic [1:0] {IDLE, EVAL, FETCH_A, FETCH_D} state_t;
  state_t state, nxt;
  logic [31:0] attr [NUM_SPRITES];
  logic [IW-1:0] idx;
  logic [NW-1:0] n;
  logic [MAX_PER_LINE-1:0] s_valid, s_hf;
  logic [9:0] s_x [MAX_PER_LINE];
  logic [2:0] s_pal [MAX_PER_LINE];
  logic [SPRITE_W*BPP-1:0] s_row [MAX_PER_LINE];
  logic [9:0] nl, y, row, px, off;
  logic hit, free, last, start, found, vis;
  logic [OW-1:0] o;
  logic [BPP-1:0] p;
  logic [2+BPP:0] color;
  assign nl    = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
  assign y     = attr[idx][9:0];
  assign row   = nl - y;
  assign hit   = y != 10'h3FF && row < 10'(SPRITE_H);
  assign free  = n < NW'(MAX_PER_LINE);
  assign last  = idx == IW'(NUM_SPRITES - 1);
  assign start = hcount == 11'd1280;
  assign px    = hcount[10:1];
  assign vis   = hcount < 11'd1280 && vcount < 10'd480;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE    ? (start ? EVAL : IDLE) :
          state == EVAL    ? (hit && free ? FETCH_A : last ? IDLE : EVAL) :
          state == FETCH_A ? FETCH_D : (last ? IDLE : EVAL);
  always_comb busy = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) attr[i] <= 32'h3FF;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        s_x[i]   <= '0;
        s_pal[i] <= '0;
        s_row[i] <= '0;
      end
      idx      <= '0;
      n        <= '0;
      s_valid  <= '0;
      s_hf     <= '0;
      pat_addr <= '0;
      overflow <= 1'b0;
    end else begin
      if (attr_we) attr[attr_addr] <= attr_wdata;
      if (state == IDLE && start) begin
        s_valid <= '0;
        idx     <= '0;
        n       <= '0;
        if (nl == 10'd0) overflow <= 1'b0;
      end
      if (state == EVAL) begin
        if (hit && free) begin
          pat_addr            <= attr[idx][27:20] + row[7:0];
          s_x[n[SW-1:0]]      <= attr[idx][19:10];
          s_pal[n[SW-1:0]]    <= attr[idx][30:28];
          s_hf[n[SW-1:0]]     <= attr[idx][31];
        end else begin
          if (hit) overflow <= 1'b1;
          idx <= idx + 1'b1;
        end
      end
      if (state == FETCH_D) begin
        s_row[n[SW-1:0]]   <= pat_rdata;
        s_valid[n[SW-1:0]] <= 1'b1;
        n                  <= n + 1'b1;
        idx                <= idx + 1'b1;
      end
    end
  // scan high to low so the lowest slot with an opaque pixel wins
  always_comb begin
    found = 1'b0;
    color = '0;
    off   = '0;
    o     = '0;
    p     = '0;
    for (int k = MAX_PER_LINE - 1; k >= 0; k--) begin
      off = px - s_x[k];
      o   = s_hf[k] ? OW'(SPRITE_W - 1) - off[OW-1:0] : off[OW-1:0];
      p   = s_row[k][o*BPP +: BPP];
      if (s_valid[k] && off < 10'(SPRITE_W) && p != '0) begin
        found = 1'b1;
        color = {s_pal[k], p};
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pix_valid <= 1'b0;
      pix_color <= '0;
    end else begin
      pix_valid <= vis && found;
      pix_color <= (vis && found) ? color : '0;
    end
endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine: directed scanline scenarios with a scoreboard queue checked by a pixel monitor
module tb_sprite_line_engine;
  logic clk = 1'b0, reset = 1'b1, attr_we = 1'b0;
  logic [3:0] attr_addr = '0;
  logic [31:0] attr_wdata = '0;
  logic [10:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic [7:0] pat_addr;
  logic [31:0] pat_rdata = '0;
  logic pix_valid, overflow, busy;
  logic [4:0] pix_color;
  logic [31:0] pmem [256];
  logic req = 1'b0, req_d = 1'b0, exp_ovf = 1'b0;
  int total = 0, bad = 0;
  typedef struct {string name; logic v; logic [4:0] c; logic o;} exp_t;
  exp_t q[$];
  exp_t e;

  always #10 clk = ~clk;

  sprite_line_engine dut (
    .clk(clk), .reset(reset), .attr_we(attr_we), .attr_addr(attr_addr), .attr_wdata(attr_wdata),
    .hcount(hcount), .vcount(vcount), .pat_addr(pat_addr), .pat_rdata(pat_rdata),
    .pix_valid(pix_valid), .pix_color(pix_color), .overflow(overflow), .busy(busy)
  );

  always @(posedge clk) begin
    pat_rdata <= pmem[pat_addr];
    req_d <= req;
  end

  always @(negedge clk)
    if (req_d) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: output presented with no expectation queued");
      end else begin
        e = q.pop_front();
        if (pix_valid !== e.v || pix_color !== e.c || overflow !== e.o) begin
          bad++;
          $display("FAIL %s: got valid=%0b color=%b ovf=%0b, want valid=%0b color=%b ovf=%0b",
                   e.name, pix_valid, pix_color, overflow, e.v, e.c, e.o);
        end
      end
    end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic wr(input int i, input int y, input int x, input int base, input int pal, input bit hf);
    @(negedge clk);
    attr_we = 1'b1;
    attr_addr = 4'(i);
    attr_wdata = {hf, 3'(pal), 8'(base), 10'(x), 10'(y)};
    @(negedge clk);
    attr_we = 1'b0;
  endtask

  task automatic eval_line(input int nl);
    int cyc;
    @(negedge clk);
    vcount = (nl == 0) ? 10'd524 : 10'(nl - 1);
    hcount = 11'd1280;
    @(negedge clk);
    hcount = 11'd1281;
    chk("busy_start", busy, 1);
    cyc = 0;
    while (busy && cyc < 300) begin
      @(negedge clk);
      cyc++;
      hcount = hcount + 11'd1;
    end
    chk("eval_done", busy, 0);
  endtask

  task automatic pix(input string name, input int line, input int x, input bit v, input logic [4:0] c);
    exp_t t;
    @(negedge clk);
    vcount = 10'(line);
    hcount = 11'(x * 2);
    t.name = name;
    t.v = v;
    t.c = c;
    t.o = exp_ovf;
    q.push_back(t);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) pmem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", pix_valid, 0);
    chk("rst_color", pix_color, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pat_addr", pat_addr, 0);
    reset = 1'b0;
    // single sprite, first row only
    pmem[0] = 32'h1;
    wr(0, 10, 20, 0, 1, 0);
    eval_line(10);
    pix("t1_px20", 10, 20, 1, 5'b00101);
    pix("t1_px21", 10, 21, 0, 5'b0);
    pix("t1_px19", 10, 19, 0, 5'b0);
    eval_line(11);
    pix("t1_row1", 11, 20, 0, 5'b0);
    wr(0, 1023, 0, 0, 0, 0);
    // index priority between overlapping sprites
    pmem[10] = 32'h2;
    pmem[20] = 32'h5;
    wr(2, 50, 100, 10, 2, 0);
    wr(5, 50, 100, 20, 3, 0);
    eval_line(50);
    pix("t2_prio", 50, 100, 1, 5'b01010);
    pix("t2_px101", 50, 101, 1, 5'b01101);
    pmem[10] = 32'h0;
    eval_line(50);
    pix("t2_fallthru", 50, 100, 1, 5'b01101);
    wr(2, 1023, 0, 0, 0, 0);
    wr(5, 1023, 0, 0, 0, 0);
    // horizontal flip
    pmem[40] = 32'h3;
    wr(1, 200, 40, 40, 4, 1);
    eval_line(200);
    pix("t4_px55", 200, 55, 1, 5'b10011);
    pix("t4_px40", 200, 40, 0, 5'b0);
    wr(1, 1023, 0, 0, 0, 0);
    // line 0 from line 524, right-edge clipping, bottom rows
    pmem[50] = 32'hFFFF_FFFF;
    wr(3, 0, 630, 50, 5, 0);
    eval_line(0);
    pix("t5_px630", 0, 630, 1, 5'b10111);
    pix("t5_px639", 0, 639, 1, 5'b10111);
    pix("t5_px0", 0, 0, 0, 5'b0);
    pix("t5_px5", 0, 5, 0, 5'b0);
    for (int i = 60; i < 76; i++) pmem[i] = 32'h1;
    wr(3, 470, 300, 60, 6, 0);
    eval_line(470);
    pix("t5_row0", 470, 300, 1, 5'b11001);
    eval_line(479);
    pix("t5_row9", 479, 300, 1, 5'b11001);
    eval_line(480);
    pix("t5_row10_blank", 480, 300, 0, 5'b0);
    wr(3, 1023, 0, 0, 0, 0);
    // overflow with nine sprites on one line
    pmem[30] = 32'h3;
    for (int i = 0; i < 9; i++) wr(i, 100, 200 + 20 * i, 30, i % 8, 0);
    eval_line(100);
    exp_ovf = 1'b1;
    pix("t3_e0", 100, 200, 1, 5'b00011);
    pix("t3_e7", 100, 340, 1, 5'b11111);
    pix("t3_e8_dropped", 100, 360, 0, 5'b0);
    eval_line(5);
    pix("t3_sticky", 5, 200, 0, 5'b0);
    eval_line(0);
    exp_ovf = 1'b0;
    pix("t3_cleared", 0, 200, 0, 5'b0);
    // reset in the middle of evaluation
    eval_line(100);
    exp_ovf = 1'b1;
    pix("t6_pre", 100, 200, 1, 5'b00011);
    @(negedge clk);
    vcount = 10'd99;
    hcount = 11'd1280;
    @(negedge clk);
    hcount = 11'd1281;
    repeat (3) @(negedge clk);
    chk("t6_busy_mid", busy, 1);
    chk("t6_addr_mid", pat_addr, 30);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_addr", pat_addr, 0);
    chk("t6_rst_valid", pix_valid, 0);
    chk("t6_rst_color", pix_color, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_ovf = 1'b0;
    wr(0, 100, 200, 30, 0, 0);
    eval_line(100);
    pix("t6_post_e0", 100, 200, 1, 5'b00011);
    pix("t6_post_e1_gone", 100, 220, 0, 5'b0);
    begin
      int w = 0;
      while (q.size() != 0 && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    chk("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
